vram_arbiter: RTL and testbench

//  Responder side of the video fetch interface (RD/DA/DD) of the MC6847 VGA

---
 rtl/vram_arbiter_if.sv | 44 ++++
 rtl/vram_arbiter.sv | 118 +++++++++++
 tb/tb_vram_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - video fetch, CPU and SRAM bus bundle for vram_arbiter
//
// Purpose: groups the video read port (VID_*), the Z80 access port (CPU_*),
// the synchronous SRAM port (MEM_*) and the snow counter into one bundle.
// Ports (signals):
//   VID_RD, VID_DA          video read request and address (requester -> arbiter)
//   VID_DD                  video read data (arbiter -> requester)
//   CPU_REQ, CPU_WR, CPU_A, CPU_DO   CPU access request (requester -> arbiter)
//   CPU_DI, CPU_ACK, CPU_WAIT        CPU read data and handshake (arbiter -> requester)
//   MEM_A, MEM_WE, MEM_D    SRAM address/write strobe/write data (arbiter -> SRAM)
//   MEM_Q                   SRAM read data (SRAM -> arbiter)
//   SNOW_CNT                dropped video read count (arbiter -> requester)
// Modports: master = requester/SRAM side, slave = arbiter side.

interface vram_arbiter_if #(
   parameter int AW     = 13,
   parameter int SNOW_W = 16
);
   logic              VID_RD;
   logic [AW-1:0]     VID_DA;
   logic [7:0]        VID_DD;
   logic              CPU_REQ;
   logic              CPU_WR;
   logic [AW-1:0]     CPU_A;
   logic [7:0]        CPU_DO;
   logic [7:0]        CPU_DI;
   logic              CPU_ACK;
   logic              CPU_WAIT;
   logic [AW-1:0]     MEM_A;
   logic              MEM_WE;
   logic [7:0]        MEM_D;
   logic [7:0]        MEM_Q;
   logic [SNOW_W-1:0] SNOW_CNT;

   modport master (
      output VID_RD, VID_DA, CPU_REQ, CPU_WR, CPU_A, CPU_DO, MEM_Q,
      input  VID_DD, CPU_DI, CPU_ACK, CPU_WAIT, MEM_A, MEM_WE, MEM_D, SNOW_CNT
   );

   modport slave (
      input  VID_RD, VID_DA, CPU_REQ, CPU_WR, CPU_A, CPU_DO, MEM_Q,
      output VID_DD, CPU_DI, CPU_ACK, CPU_WAIT, MEM_A, MEM_WE, MEM_D, SNOW_CNT
   );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - one-access-per-clock VRAM arbiter between video fetch and Z80
//
// Purpose: shares one synchronous SRAM between the MC6847 video fetch and the
// Z80. Video has priority; a CPU access that has waited MAX_WAIT cycles steals
// one slot from video (the dropped video read is counted in SNOW_CNT).
// Ports:
//   PIX_CLK  in   single clock, rising edge
//   RESET    in   synchronous, active-high
//   bus      slave modport of vram_arbiter_if (VID_*, CPU_*, MEM_*, SNOW_CNT)
// Timing: an access issued at edge k drives MEM_A from k; SRAM data is valid
// after k+1 and is captured at k+2. CPU writes acknowledge at k+1, CPU reads
// at k+2 with CPU_DI.

module vram_arbiter #(
   parameter int AW       = 13,
   parameter int MAX_WAIT = 8,
   parameter int SNOW_W   = 16
) (
   input  logic          PIX_CLK,
   input  logic          RESET,
   vram_arbiter_if.slave bus
);

   localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

   typedef enum logic [1:0] {
      OP_NONE,
      OP_VID,
      OP_CRD,
      OP_CWR
   } op_t;

   op_t           s1_op;      // op whose address is on MEM_A this cycle
   op_t           s2_op;      // read op whose data is on MEM_Q this cycle
   logic          busy;
   logic [WW-1:0] wait_cnt;

   logic preempt;
   logic grant_vid;
   logic grant_cpu;

   always_comb begin
      preempt   = 1'b0;
      grant_vid = 1'b0;
      grant_cpu = 1'b0;
      if ((MAX_WAIT != 0) && bus.CPU_REQ && !busy && (wait_cnt == WAIT_MAX)) begin
         preempt   = 1'b1;
         grant_cpu = 1'b1;
      end else if (bus.VID_RD) begin
         grant_vid = 1'b1;
      end else if (bus.CPU_REQ && !busy) begin
         grant_cpu = 1'b1;
      end
   end

   // CPU_ACK is registered, so this only ever deasserts WAIT in the ack cycle.
   assign bus.CPU_WAIT = bus.CPU_REQ & ~bus.CPU_ACK;

   always_ff @(posedge PIX_CLK) begin
      if (RESET) begin
         s1_op        <= OP_NONE;
         s2_op        <= OP_NONE;
         busy         <= 1'b0;
         wait_cnt     <= '0;
         bus.VID_DD   <= 8'h00;
         bus.CPU_DI   <= 8'h00;
         bus.CPU_ACK  <= 1'b0;
         bus.MEM_A    <= '0;
         bus.MEM_WE   <= 1'b0;
         bus.MEM_D    <= 8'h00;
         bus.SNOW_CNT <= '0;
      end else begin
         // Issue stage; MEM_A holds its last value on idle cycles.
         if (grant_cpu) begin
            bus.MEM_A <= bus.CPU_A;
            s1_op     <= bus.CPU_WR ? OP_CWR : OP_CRD;
         end else if (grant_vid) begin
            bus.MEM_A <= bus.VID_DA;
            s1_op     <= OP_VID;
         end else begin
            s1_op     <= OP_NONE;
         end
         bus.MEM_WE <= grant_cpu & bus.CPU_WR;
         bus.MEM_D  <= bus.CPU_DO;

         // Writes finish once the SRAM has taken them; reads move on to capture.
         s2_op <= (s1_op == OP_CWR) ? OP_NONE : s1_op;

         if (s2_op == OP_VID) begin
            bus.VID_DD <= bus.MEM_Q;
         end
         if (s2_op == OP_CRD) begin
            bus.CPU_DI <= bus.MEM_Q;
         end
         bus.CPU_ACK <= (s1_op == OP_CWR) || (s2_op == OP_CRD);

         // busy stays set through the ack cycle so a REQ still held there
         // cannot issue the same access a second time.
         if (grant_cpu) begin
            busy <= 1'b1;
         end else if (bus.CPU_ACK) begin
            busy <= 1'b0;
         end

         if (grant_cpu || !bus.CPU_REQ) begin
            wait_cnt <= '0;
         end else if (!busy && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
         end

         if (preempt && bus.VID_RD && (bus.SNOW_CNT != {SNOW_W{1'b1}})) begin
            bus.SNOW_CNT <= bus.SNOW_CNT + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter

module tb_vram_arbiter;

   localparam int MAXW = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   vram_arbiter_if #(.AW(13), .SNOW_W(16)) bus8 ();
   vram_arbiter_if #(.AW(13), .SNOW_W(16)) bus0 ();

   vram_arbiter #(.AW(13), .MAX_WAIT(MAXW), .SNOW_W(16)) dut8 (
      .PIX_CLK(clk), .RESET(rst), .bus(bus8));
   vram_arbiter #(.AW(13), .MAX_WAIT(0), .SNOW_W(16)) dut0 (
      .PIX_CLK(clk), .RESET(rst), .bus(bus0));

   // synchronous SRAM models: data for the address presented at edge k is on MEM_Q after k+1
   logic [7:0] ram8 [8192];
   logic [7:0] ram0 [8192];
   always @(posedge clk) begin
      if (bus8.MEM_WE) ram8[bus8.MEM_A] = bus8.MEM_D;
      bus8.MEM_Q <= ram8[bus8.MEM_A];
   end
   always @(posedge clk) begin
      if (bus0.MEM_WE) ram0[bus0.MEM_A] = bus0.MEM_D;
      bus0.MEM_Q <= ram0[bus0.MEM_A];
   end

   // reference model for the MAX_WAIT=8 instance: completions kept as a list of
   // (due edge, kind, data) events; memory contents tracked at issue time
   typedef struct {
      int         due;
      int         kind;   // 0 video read, 1 cpu read, 2 cpu write
      logic [7:0] data;
   } ev_t;

   ev_t        evq[$];
   logic [7:0] ref_ram [8192];
   int         n = 0;
   logic [7:0] m_vdd, m_cdi, m_memd;
   logic [12:0] m_mema;
   logic       m_ack, m_we, m_busy;
   int         m_wait, m_snow;

   task automatic model_reset();
      m_vdd = 0; m_cdi = 0; m_memd = 0; m_mema = 0;
      m_ack = 0; m_we = 0; m_busy = 0; m_wait = 0; m_snow = 0;
      evq.delete();
   endtask

   task automatic model_edge();
      logic gcpu, gvid, busy_old, ack_old, new_ack;
      n++;
      if (rst) begin
         model_reset();
         return;
      end
      busy_old = m_busy;
      ack_old  = m_ack;
      gcpu = 0; gvid = 0;
      if (bus8.CPU_REQ && !busy_old && m_wait == MAXW) begin
         gcpu = 1;
         if (bus8.VID_RD && m_snow < 65535) m_snow++;
      end else if (bus8.VID_RD) begin
         gvid = 1;
      end else if (bus8.CPU_REQ && !busy_old) begin
         gcpu = 1;
      end
      new_ack = 0;
      for (int j = evq.size() - 1; j >= 0; j--) begin
         if (evq[j].due == n) begin
            if (evq[j].kind == 0) m_vdd = evq[j].data;
            if (evq[j].kind == 1) m_cdi = evq[j].data;
            if (evq[j].kind != 0) new_ack = 1;
            evq.delete(j);
         end
      end
      m_ack = new_ack;
      if (gcpu) m_busy = 1;
      else if (ack_old) m_busy = 0;
      if (gcpu || !bus8.CPU_REQ) m_wait = 0;
      else if (!busy_old && m_wait < MAXW) m_wait++;
      if (gcpu) begin
         m_mema = bus8.CPU_A;
         if (bus8.CPU_WR) begin
            ref_ram[bus8.CPU_A] = bus8.CPU_DO;
            evq.push_back('{n + 1, 2, 8'h00});
         end else begin
            evq.push_back('{n + 2, 1, ref_ram[bus8.CPU_A]});
         end
      end else if (gvid) begin
         m_mema = bus8.VID_DA;
         evq.push_back('{n + 2, 0, ref_ram[bus8.VID_DA]});
      end
      m_we   = gcpu & bus8.CPU_WR;
      m_memd = bus8.CPU_DO;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      chk("VID_DD", bus8.VID_DD, m_vdd);
      chk("CPU_DI", bus8.CPU_DI, m_cdi);
      chk("CPU_ACK", bus8.CPU_ACK, m_ack);
      chk("CPU_WAIT", bus8.CPU_WAIT, bus8.CPU_REQ & ~m_ack);
      chk("MEM_A", bus8.MEM_A, m_mema);
      chk("MEM_WE", bus8.MEM_WE, m_we);
      chk("MEM_D", bus8.MEM_D, m_memd);
      chk("SNOW_CNT", bus8.SNOW_CNT, m_snow[15:0]);
   endtask

   task automatic cpu_op(input logic wr, input logic [12:0] a, input logic [7:0] d,
                         output int lat);
      bus8.CPU_REQ = 1; bus8.CPU_WR = wr; bus8.CPU_A = a; bus8.CPU_DO = d;
      lat = 0;
      do begin
         cycle();
         lat++;
      end while (bus8.CPU_ACK !== 1'b1 && lat < 30);
      bus8.CPU_REQ = 0;
   endtask

   initial begin
      int         lat, acks, wlow;
      logic [7:0] prev_vdd;

      for (int i = 0; i < 8192; i++) begin
         ram8[i]    = 8'(i) ^ 8'h5A;
         ram0[i]    = 8'(i) ^ 8'h5A;
         ref_ram[i] = 8'(i) ^ 8'h5A;
      end
      model_reset();
      bus8.VID_RD = 0; bus8.VID_DA = 0; bus8.CPU_REQ = 0; bus8.CPU_WR = 0;
      bus8.CPU_A = 0; bus8.CPU_DO = 0;
      bus0.VID_RD = 0; bus0.VID_DA = 0; bus0.CPU_REQ = 0; bus0.CPU_WR = 0;
      bus0.CPU_A = 0; bus0.CPU_DO = 0;

      // reset state
      rst = 1;
      cycle();
      cycle();
      rst = 0;
      chk("rst_vid_dd", bus8.VID_DD, 0);
      chk("rst_ack", bus8.CPU_ACK, 0);
      chk("rst_snow", bus8.SNOW_CNT, 0);

      // reset while a CPU read is in flight
      bus8.CPU_REQ = 1; bus8.CPU_WR = 0; bus8.CPU_A = 13'h0010;
      cycle();
      rst = 1; bus8.CPU_REQ = 0;
      cycle();
      rst = 0;
      chk("midrst_cpu_di", bus8.CPU_DI, 0);
      chk("midrst_mem_a", bus8.MEM_A, 0);
      chk("midrst_mem_we", bus8.MEM_WE, 0);
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (bus8.CPU_ACK === 1'b1) acks++;
      end
      chk("midrst_no_ack", acks, 0);

      // video only, one read per cycle
      bus8.VID_RD = 1;
      for (int i = 0; i < 32; i++) begin
         bus8.VID_DA = 13'(i);
         cycle();
      end
      bus8.VID_RD = 0;
      cycle();
      cycle();
      chk("vid_last", bus8.VID_DD, 8'h45);

      // CPU write then read back
      cpu_op(1'b1, 13'h1234, 8'hA5, lat);
      chk("wr_latency", lat, 2);
      cycle();
      cpu_op(1'b0, 13'h1234, 8'h00, lat);
      chk("rd_latency", lat, 3);
      chk("rd_data", bus8.CPU_DI, 8'hA5);
      cycle();

      // contention: CPU read starved by continuous video reads
      bus8.VID_RD = 1; bus8.CPU_REQ = 1; bus8.CPU_WR = 0; bus8.CPU_A = 13'h0042;
      lat = 0;
      do begin
         bus8.VID_DA = 13'($urandom_range(0, 8191));
         prev_vdd = bus8.VID_DD;
         cycle();
         lat++;
      end while (bus8.CPU_ACK !== 1'b1 && lat < 30);
      chk("cont_latency", lat, 11);
      chk("cont_vid_hold", bus8.VID_DD, prev_vdd);
      chk("cont_snow", bus8.SNOW_CNT, 1);
      chk("cont_data", bus8.CPU_DI, 8'h18);
      bus8.CPU_REQ = 0; bus8.VID_RD = 0;
      cycle();
      cycle();

      // same-edge CPU write and video read to one address
      bus8.VID_RD = 1; bus8.VID_DA = 13'h0100;
      bus8.CPU_REQ = 1; bus8.CPU_WR = 1; bus8.CPU_A = 13'h0100; bus8.CPU_DO = 8'h3C;
      cycle();
      chk("same_first_we", bus8.MEM_WE, 0);
      bus8.VID_RD = 0;
      cycle();
      chk("same_wr_we", bus8.MEM_WE, 1);
      chk("same_wr_a", bus8.MEM_A, 13'h0100);
      cycle();
      chk("same_ack", bus8.CPU_ACK, 1);
      chk("same_old_data", bus8.VID_DD, 8'h5A);
      bus8.CPU_REQ = 0;
      bus8.VID_RD = 1;
      cycle();
      bus8.VID_RD = 0;
      cycle();
      cycle();
      chk("same_new_data", bus8.VID_DD, 8'h3C);

      // MAX_WAIT=0 instance: CPU never preempts video
      bus0.VID_RD = 1; bus0.CPU_REQ = 1; bus0.CPU_WR = 0; bus0.CPU_A = 13'h0005;
      acks = 0; wlow = 0;
      for (int i = 0; i < 100; i++) begin
         bus0.VID_DA = 13'(i);
         cycle();
         if (bus0.CPU_ACK !== 1'b0) acks++;
         if (bus0.CPU_WAIT !== 1'b1) wlow++;
      end
      chk("nw_no_ack", acks, 0);
      chk("nw_wait_held", wlow, 0);
      chk("nw_snow", bus0.SNOW_CNT, 0);
      bus0.VID_RD = 0;
      lat = 0;
      do begin
         cycle();
         lat++;
      end while (bus0.CPU_ACK !== 1'b1 && lat < 10);
      chk("nw_latency", lat, 3);
      chk("nw_data", bus0.CPU_DI, 8'h5F);
      bus0.CPU_REQ = 0;

      // randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         bus8.VID_RD = ($urandom_range(0, 9) < 8);
         bus8.VID_DA = 13'($urandom_range(0, 15));
         rst = (i == 200);
         if (bus8.CPU_REQ) begin
            if (bus8.CPU_ACK || rst || (m_busy && $urandom_range(0, 19) == 0))
               bus8.CPU_REQ = 0;
         end else if ($urandom_range(0, 3) == 0) begin
            bus8.CPU_REQ = 1;
            bus8.CPU_WR  = 1'($urandom_range(0, 1));
            bus8.CPU_A   = 13'($urandom_range(0, 15));
            bus8.CPU_DO  = 8'($urandom);
         end
         cycle();
      end
      rst = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
